// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - borrow_in, LSB first, one full-subtractor cell
// Status flags are registered once on the final shift edge and held until the next result.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d_bit;
  logic             bo_bit;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor cell on the current LSBs and the running borrow.
  always_comb begin
    d_bit    = a_sr[0] ^ b_sr[0] ^ br;
    bo_bit   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    res_next = {d_bit, res_sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      difference <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            br     <= borrow_in;
            res_sr <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          br     <= bo_bit;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            // br still holds the borrow into the MSB here, so overflow is a single XOR.
            difference <= res_next;
            borrow_out <= bo_bit;
            overflow   <= br ^ bo_bit;
            zero       <= (res_next == '0);
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
